// File: rtl/buzzer_player.sv
// buzzer_player
//   Walks the buzzer music ROM from address 0 and turns each 12-bit note word
//   into a square wave on the buzzer pad.
//   Note word: [11:8] duration in beats, [7:0] half-period in tone ticks
//   (0 = rest). Word 12'h000 ends the song.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   start     level; begins playback from address 0 when idle
//   stop      level; aborts playback (no done pulse), wins over start
//   loop_en   at end of song restart from address 0 instead of finishing
//   rom_en    ROM read enable, high for the single FETCH cycle
//   rom_addr  ROM read address
//   rom_data  ROM registered output, valid one clock after rom_en
//   buzzer_o  square-wave drive to the buzzer
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse on natural end of song
module buzzer_player #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 12,
    parameter int TONE_DIV    = 50,
    parameter int BEAT_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  buzzer_o,
    output logic                  busy,
    output logic                  done
);

    // Counters sized for the largest field values (dur=15, tone=255).
    localparam int DUR_W = $clog2(15 * BEAT_CYCLES + 1);
    localparam int HP_W  = $clog2(255 * TONE_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            tone;
    logic [3:0]            dur;
    logic [DUR_W-1:0]      dur_cnt;
    logic [HP_W-1:0]       hp_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    logic [DUR_W-1:0]      note_len;
    logic [HP_W-1:0]       half_len;
    logic                  at_last;
    logic                  gap_last;
    logic                  word_zero;
    logic                  word_skip;
    logic                  song_end;
    logic                  advance;

    assign rom_en   = (state == S_FETCH);
    assign rom_addr = addr;
    assign busy     = (state != S_IDLE);

    always_comb begin
        note_len  = DUR_W'(dur) * DUR_W'(BEAT_CYCLES);
        half_len  = HP_W'(tone) * HP_W'(TONE_DIV);
        at_last   = (addr == '1);
        gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
        word_zero = (rom_data[11:0] == 12'h000);
        // A zero-duration tone is skipped without a gap.
        word_skip = !word_zero && (rom_data[11:8] == 4'd0);
        // The last address never wraps: it ends the song whether it came
        // from a finished gap or from a skipped word.
        song_end  = ((state == S_LATCH) && (word_zero || (word_skip && at_last)))
                 || ((state == S_GAP) && gap_last && at_last);
        advance   = ((state == S_LATCH) && word_skip && !at_last)
                 || ((state == S_GAP) && gap_last && !at_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            tone     <= '0;
            dur      <= '0;
            dur_cnt  <= '0;
            hp_cnt   <= '0;
            gap_cnt  <= '0;
            buzzer_o <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= S_IDLE;
                buzzer_o <= 1'b0;
            end else if (song_end) begin
                addr     <= '0;
                buzzer_o <= 1'b0;
                if (loop_en) begin
                    state <= S_FETCH;
                end else begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
            end else if (advance) begin
                addr     <= addr + ADDR_WIDTH'(1);
                buzzer_o <= 1'b0;
                state    <= S_FETCH;
            end else begin
                case (state)
                    S_IDLE: begin
                        buzzer_o <= 1'b0;
                        if (start) begin
                            addr  <= '0;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state <= S_LATCH;
                    end
                    S_LATCH: begin
                        tone     <= rom_data[7:0];
                        dur      <= rom_data[11:8];
                        dur_cnt  <= '0;
                        hp_cnt   <= '0;
                        buzzer_o <= 1'b0;
                        state    <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (dur_cnt == note_len - DUR_W'(1)) begin
                            buzzer_o <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                            if (tone == 8'd0) begin
                                buzzer_o <= 1'b0;
                            end else if (hp_cnt == half_len - HP_W'(1)) begin
                                hp_cnt   <= '0;
                                buzzer_o <= ~buzzer_o;
                            end else begin
                                hp_cnt <= hp_cnt + HP_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        buzzer_o <= 1'b0;
                        gap_cnt  <= gap_cnt + GAP_W'(1);
                    end
                    default: begin
                        state    <= S_IDLE;
                        buzzer_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_player.sv
// tb_buzzer_player
//   Directed bench for buzzer_player with small timing parameters
//   (TONE_DIV=2, BEAT_CYCLES=20, GAP_CYCLES=4, ADDR_WIDTH=3) and a
//   behavioural ROM with one clock of read latency.
module tb_buzzer_player;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [11:0] rom_data;
    logic        buzzer_o;
    logic        busy;
    logic        done;

    logic [11:0] mem [0:7];

    int checks;
    int errors;

    buzzer_player #(
        .ADDR_WIDTH (3),
        .DATA_WIDTH (12),
        .TONE_DIV   (2),
        .BEAT_CYCLES(20),
        .GAP_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .buzzer_o(buzzer_o),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] fill);
        for (int i = 0; i < 8; i++) mem[i] = fill;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered in the FETCH cycle; leaves two cycles later (PLAY or next state).
    task automatic fetch_check(input logic [2:0] a);
        check("fetch_en", 32'(rom_en), 32'd1);
        check("fetch_addr", 32'(rom_addr), 32'(a));
        check("fetch_busy", 32'(busy), 32'd1);
        step();
        check("latch_en", 32'(rom_en), 32'd0);
        step();
    endtask

    // Entered in PLAY cycle 0; half = half-period in clocks (0 for a rest).
    task automatic note_check(input int half, input int len);
        for (int c = 0; c < len; c++) begin
            check("note_buz", 32'(buzzer_o), (half == 0) ? 32'd0 : 32'((c / half) % 2));
            step();
        end
    endtask

    task automatic gap_check();
        for (int g = 0; g < 4; g++) begin
            check("gap_buz", 32'(buzzer_o), 32'd0);
            check("gap_en", 32'(rom_en), 32'd0);
            check("gap_busy", 32'(busy), 32'd1);
            step();
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        rom_data = 12'h000;
        load_rom(12'h205, 12'h300, 12'h000, 12'h000);

        // Reset state
        repeat (3) step();
        check("rst_en", 32'(rom_en), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_buz", 32'(buzzer_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        // T1: tone, rest, end marker
        pulse_start();
        fetch_check(3'd0);
        note_check(10, 40);
        gap_check();
        fetch_check(3'd1);
        note_check(0, 60);
        gap_check();
        fetch_check(3'd2);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_en", 32'(rom_en), 32'd0);
        step();
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // T2: looping, three passes with no done pulse
        loop_en = 1'b1;
        pulse_start();
        for (int l = 0; l < 3; l++) begin
            fetch_check(3'd0);
            note_check(10, 40);
            gap_check();
            fetch_check(3'd1);
            note_check(0, 60);
            gap_check();
            fetch_check(3'd2);
            check("t2_nodone", 32'(done), 32'd0);
            check("t2_refetch", 32'(rom_addr), 32'd0);
        end
        check("t2_fetch0", 32'(rom_en), 32'd1);
        stop = 1'b1;
        step();
        stop    = 1'b0;
        loop_en = 1'b0;
        check("t2_stop_busy", 32'(busy), 32'd0);
        check("t2_stop_done", 32'(done), 32'd0);
        check("t2_stop_en", 32'(rom_en), 32'd0);
        step();

        // T3: stop 15 clocks into note 0, then replay
        pulse_start();
        fetch_check(3'd0);
        note_check(10, 15);
        check("t3_buz_hi", 32'(buzzer_o), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_buz", 32'(buzzer_o), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_en", 32'(rom_en), 32'd0);
        step();
        check("t3_stays", 32'(busy), 32'd0);
        pulse_start();
        fetch_check(3'd0);
        note_check(10, 12);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop2", 32'(busy), 32'd0);
        step();

        // T4: zero-duration word skipped, long half-period note stays low
        load_rom(12'h0A7, 12'h1FF, 12'h000, 12'h000);
        pulse_start();
        fetch_check(3'd0);
        fetch_check(3'd1);
        note_check(510, 20);
        gap_check();
        fetch_check(3'd2);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        step();

        // T5: full ROM with no end marker, no wrap to address 0
        load_rom(12'h101, 12'h101, 12'h101, 12'h101);
        pulse_start();
        for (int a = 0; a < 8; a++) begin
            fetch_check(3'(a));
            note_check(2, 20);
            gap_check();
        end
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_nowrap", 32'(rom_en), 32'd0);
        step();
        check("t5_idle_en", 32'(rom_en), 32'd0);
        check("t5_done_off", 32'(done), 32'd0);

        // T6: asynchronous reset mid-note, then start+stop together in IDLE
        load_rom(12'h205, 12'h300, 12'h000, 12'h000);
        pulse_start();
        fetch_check(3'd0);
        note_check(10, 12);
        check("t6_buz_hi", 32'(buzzer_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_buz", 32'(buzzer_o), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_en", 32'(rom_en), 32'd0);
        check("t6_async_addr", 32'(rom_addr), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("t6_noresume", 32'(busy), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t6_ss_busy", 32'(busy), 32'd0);
        check("t6_ss_en", 32'(rom_en), 32'd0);
        step();
        check("t6_ss_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
